f2f_frame_tx: RTL

F2F_FRAME_TX -- requirements
Module: f2f_frame_tx

---
 rtl/f2f_frame_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/f2f_frame_tx.sv
// f2f_frame_tx
// Frames float<->fixed conversion requests into 48-bit FIFO words: one header
// word followed by one or two payload words.
//
// Ports:
//   clk, rstn     single clock, asynchronous active-low reset
//   req_valid     request present
//   req_ready     high only while idle (request can be accepted)
//   req_app       2'b00 float-to-fixed, 2'b01 fixed-to-float, others illegal
//   req_size      width code 1..3 legal, 0 and 4..7 illegal
//   req_payload   80-bit operand, MSB-aligned
//   fifo_full     downstream FIFO full (stalls the frame)
//   fifo_wren     write strobe (combinational from state and fifo_full)
//   fifo_dout     registered word for the current state
//   busy          frame in progress
//   err           one-cycle pulse when an illegal request is dropped
//
// Configuration:
//   F2F_TX_SEQ_TAG_EN  when defined, the header tag is an 8-bit sequence
//                      counter bumped at the end of each legal frame;
//                      otherwise the tag field is constant 8'h00.
module f2f_frame_tx (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_app,
    input  logic [2:0]  req_size,
    input  logic [79:0] req_payload,
    input  logic        fifo_full,
    output logic        fifo_wren,
    output logic [47:0] fifo_dout,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PL1  = 2'd2,
        S_PL2  = 2'd3
    } state_t;

    state_t       r_state;
    logic [1:0]   r_app;
    logic [2:0]   r_size;
    logic [79:0]  r_payload;
    logic [47:0]  r_dout;
    logic         r_err;
    logic [7:0]   w_tag;
    logic         w_accept;
    logic         w_req_legal;

    function automatic logic f_legal(input logic [1:0] app, input logic [2:0] size);
        f_legal = (app[1] == 1'b0) && (size != 3'd0) && (size[2] == 1'b0);
    endfunction

    // Only a float-to-fixed conversion of width code 1 fits in one word.
    function automatic logic [1:0] f_nw(input logic [1:0] app, input logic [2:0] size);
        if ((app == 2'b00) && (size == 3'd1)) begin
            f_nw = 2'd1;
        end else begin
            f_nw = 2'd2;
        end
    endfunction

    function automatic logic [47:0] f_header(input logic [1:0] app, input logic [2:0] size,
                                             input logic [7:0] tag);
        f_header = {app, size, f_nw(app, size), 33'd0, tag};
    endfunction

    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign fifo_wren   = (r_state != S_IDLE) && !fifo_full;
    assign fifo_dout   = r_dout;
    assign err         = r_err;
    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_req_legal = f_legal(req_app, req_size);

`ifdef F2F_TX_SEQ_TAG_EN
    logic [7:0] r_tag;
    logic       w_last_wr;

    // The last payload word of a frame is written either from PL1 (one-word
    // frames) or from PL2.
    assign w_last_wr = fifo_wren &&
                       (((r_state == S_PL1) && (f_nw(r_app, r_size) == 2'd1)) ||
                        (r_state == S_PL2));

    // Sequence tag: advances once per completed legal frame, wraps at 8'hFF.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tag <= 8'h00;
        end else if (w_last_wr) begin
            r_tag <= r_tag + 8'd1;
        end else begin
            r_tag <= r_tag;
        end
    end

    assign w_tag = r_tag;
`else
    assign w_tag = 8'h00;
`endif

    // Frame FSM: fifo_dout is loaded on each transition with the word the new
    // state will present, so it stays put while the FIFO back-pressures.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_app     <= 2'b00;
            r_size    <= 3'd0;
            r_payload <= 80'd0;
            r_dout    <= 48'h0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_app     <= req_app;
                        r_size    <= req_size;
                        r_payload <= req_payload;
                        if (w_req_legal) begin
                            r_dout  <= f_header(req_app, req_size, w_tag);
                            r_state <= S_HDR;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (fifo_wren) begin
                        r_dout  <= {8'h00, r_payload[79:40]};
                        r_state <= S_PL1;
                    end
                end
                S_PL1: begin
                    if (fifo_wren) begin
                        if (f_nw(r_app, r_size) == 2'd2) begin
                            r_dout  <= {8'h00, r_payload[39:0]};
                            r_state <= S_PL2;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_PL2: begin
                    if (fifo_wren) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
